// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_INST_BUSY = 2'd1,
    ARB_DATA_BUSY = 2'd2
  } arb_state_e;
  localparam logic ARB_SEL_INST = 1'b0;
  localparam logic ARB_SEL_DATA = 1'b1;
  localparam logic [2:0] FUNCT3_LW = 3'b010;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and data, with timeout
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_req,
  input  logic [XLEN-1:0] i_inst_addr,
  output logic            or_inst_ack,
  output logic [XLEN-1:0] or_inst_data,
  output logic            or_inst_err,
  input  logic            i_data_req,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic [XLEN-1:0] i_data_wdata,
  input  logic [2:0]      i_data_funct3,
  input  logic            i_data_we,
  output logic            or_data_ack,
  output logic [XLEN-1:0] or_data_rdata,
  output logic            or_data_err,
  output logic            or_mem_req,
  output logic [XLEN-1:0] or_mem_addr,
  output logic [XLEN-1:0] or_mem_wdata,
  output logic [2:0]      or_mem_funct3,
  output logic            or_mem_we,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata
);
  arb_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_grant;
  logic             eff_inst, eff_data, grant_inst, grant_data, timeout, done;
  logic [XLEN-1:0]  done_data;
  always_comb begin
    eff_inst   = i_inst_req & ~or_inst_ack;
    eff_data   = i_data_req & ~or_data_ack;
    // on contention the port that did not win last time gets the grant
    grant_inst = state == ARB_IDLE && eff_inst && (!eff_data || last_grant == ARB_SEL_DATA);
    grant_data = state == ARB_IDLE && eff_data && !grant_inst;
    timeout    = TIMEOUT_CYCLES != 0 && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    done       = state != ARB_IDLE && (i_mem_ack || timeout);
    done_data  = i_mem_ack ? i_mem_rdata : '0;
    state_next = state == ARB_IDLE ? (grant_inst ? ARB_INST_BUSY : grant_data ? ARB_DATA_BUSY : ARB_IDLE)
                                   : (done ? ARB_IDLE : state);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ARB_IDLE;
      cnt           <= '0;
      last_grant    <= ARB_SEL_DATA;
      or_inst_ack   <= 1'b0;
      or_inst_data  <= '0;
      or_inst_err   <= 1'b0;
      or_data_ack   <= 1'b0;
      or_data_rdata <= '0;
      or_data_err   <= 1'b0;
      or_mem_req    <= 1'b0;
      or_mem_addr   <= '0;
      or_mem_wdata  <= '0;
      or_mem_funct3 <= '0;
      or_mem_we     <= 1'b0;
    end else begin
      state       <= state_next;
      or_inst_ack <= done && state == ARB_INST_BUSY;
      or_data_ack <= done && state == ARB_DATA_BUSY;
      cnt         <= state == ARB_IDLE || done ? '0 : cnt + 1'b1;
      if (done) or_mem_req <= 1'b0;
      if (done && state == ARB_INST_BUSY) begin
        or_inst_data <= done_data;
        or_inst_err  <= ~i_mem_ack;
      end
      if (done && state == ARB_DATA_BUSY) begin
        or_data_rdata <= done_data;
        or_data_err   <= ~i_mem_ack;
      end
      if (grant_inst) begin
        last_grant    <= ARB_SEL_INST;
        or_mem_req    <= 1'b1;
        or_mem_addr   <= i_inst_addr;
        or_mem_wdata  <= '0;
        or_mem_funct3 <= FUNCT3_LW;
        or_mem_we     <= 1'b0;
      end else if (grant_data) begin
        last_grant    <= ARB_SEL_DATA;
        or_mem_req    <= 1'b1;
        or_mem_addr   <= i_data_addr;
        or_mem_wdata  <= i_data_wdata;
        or_mem_funct3 <= i_data_funct3;
        or_mem_we     <= i_data_we;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant order, ack masking, timeout and reset
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_data;
  logic        inst_err;
  logic        data_req;
  logic [31:0] data_addr, data_wdata;
  logic [2:0]  data_funct3;
  logic        data_we;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        mem_req;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_funct3;
  logic        mem_we;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr),
    .or_inst_ack(inst_ack), .or_inst_data(inst_data), .or_inst_err(inst_err),
    .i_data_req(data_req), .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .i_data_funct3(data_funct3), .i_data_we(data_we),
    .or_data_ack(data_ack), .or_data_rdata(data_rdata), .or_data_err(data_err),
    .or_mem_req(mem_req), .or_mem_addr(mem_addr), .or_mem_wdata(mem_wdata),
    .or_mem_funct3(mem_funct3), .or_mem_we(mem_we),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inst_req = 0; inst_addr = 0; data_req = 0; data_addr = 0;
    data_wdata = 0; data_funct3 = 0; data_we = 0; mem_ack = 0; mem_rdata = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({inst_ack, inst_data, inst_err, data_ack, data_rdata, data_err, mem_req, mem_addr, mem_wdata, mem_funct3, mem_we} !== 137'd0) begin
        bad++;
        $display("FAIL reset_outputs cycle=%0d got req=%b ack=%b/%b addr=%h", i, mem_req, inst_ack, data_ack, mem_addr);
      end
    end
  endtask

  task automatic test_fetch();
    rst = 0; inst_req = 1; inst_addr = 32'h10;
    tick();
    total++;
    if ({mem_req, mem_addr, mem_funct3, mem_we, inst_ack} !== {1'b1, 32'h10, 3'b010, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fetch_issue got req=%b addr=%h f3=%b we=%b ack=%b", mem_req, mem_addr, mem_funct3, mem_we, inst_ack);
    end
    mem_ack = 1; mem_rdata = 32'h13;
    tick();
    total++;
    if ({inst_ack, inst_data, inst_err, mem_req, data_ack} !== {1'b1, 32'h13, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL fetch_ack got ack=%b data=%h err=%b req=%b", inst_ack, inst_data, inst_err, mem_req);
    end
    mem_ack = 0;
    tick();
    total++;
    if ({inst_ack, mem_req} !== 2'b00) begin
      bad++;
      $display("FAIL ack_mask got ack=%b req=%b expected 0 0", inst_ack, mem_req);
    end
    inst_req = 0;
    mem_ack = 1; mem_rdata = 32'hFFFF;
    tick();
    total++;
    if ({inst_ack, data_ack, mem_req, inst_data} !== {3'b000, 32'h13}) begin
      bad++;
      $display("FAIL idle_mem_ack got acks=%b%b req=%b data=%h", inst_ack, data_ack, mem_req, inst_data);
    end
    mem_ack = 0;
  endtask

  task automatic test_round_robin();
    rst = 1;
    tick();
    rst = 0; inst_req = 1; inst_addr = 32'h40;
    data_req = 1; data_addr = 32'h100; data_wdata = 32'hDEADBEEF; data_funct3 = 3'b000; data_we = 1;
    for (int k = 0; k < 4; k++) begin
      bit exp_inst;
      exp_inst = (k % 2) == 0;
      tick();
      total++;
      if (exp_inst ? {mem_req, mem_addr, mem_wdata, mem_funct3, mem_we} !== {1'b1, 32'h40, 32'h0, 3'b010, 1'b0}
                   : {mem_req, mem_addr, mem_wdata, mem_funct3, mem_we} !== {1'b1, 32'h100, 32'hDEADBEEF, 3'b000, 1'b1}) begin
        bad++;
        $display("FAIL rr_grant k=%0d got req=%b addr=%h wdata=%h f3=%b we=%b", k, mem_req, mem_addr, mem_wdata, mem_funct3, mem_we);
      end
      mem_ack = 1; mem_rdata = 32'hA000 + k;
      tick();
      total++;
      if ({inst_ack, data_ack} !== (exp_inst ? 2'b10 : 2'b01) || (exp_inst ? inst_data : data_rdata) !== 32'hA000 + k) begin
        bad++;
        $display("FAIL rr_ack k=%0d got acks=%b%b idata=%h drdata=%h", k, inst_ack, data_ack, inst_data, data_rdata);
      end
      mem_ack = 0;
    end
    inst_req = 0; data_req = 0;
    tick();
  endtask

  task automatic test_timeout();
    data_req = 1; data_addr = 32'h200; data_we = 0; data_funct3 = 3'b010;
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++;
      if ({mem_req, mem_addr, data_ack} !== {1'b1, 32'h200, 1'b0}) begin
        bad++;
        $display("FAIL timeout_busy cycle=%0d got req=%b addr=%h ack=%b", c, mem_req, mem_addr, data_ack);
      end
    end
    tick();
    total++;
    if ({mem_req, data_ack, data_err, data_rdata} !== {3'b011, 32'h0}) begin
      bad++;
      $display("FAIL timeout_done got req=%b ack=%b err=%b rdata=%h", mem_req, data_ack, data_err, data_rdata);
    end
    data_req = 0;
    tick();
    total++;
    if ({mem_req, data_ack} !== 2'b00) begin
      bad++;
      $display("FAIL timeout_idle got req=%b ack=%b", mem_req, data_ack);
    end
  endtask

  task automatic test_collision();
    data_req = 1;
    for (int c = 0; c < 4; c++) tick();
    mem_ack = 1; mem_rdata = 32'h1234;
    tick();
    total++;
    if ({data_ack, data_err, data_rdata, mem_req} !== {2'b10, 32'h1234, 1'b0}) begin
      bad++;
      $display("FAIL ack_timeout_collision got ack=%b err=%b rdata=%h req=%b", data_ack, data_err, data_rdata, mem_req);
    end
    mem_ack = 0; data_req = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    data_req = 1; data_addr = 32'h300;
    tick();
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin
      bad++;
      $display("FAIL mid_busy got req=%b addr=%h", mem_req, mem_addr);
    end
    rst = 1;
    tick();
    total++;
    if ({mem_req, inst_ack, data_ack} !== 3'b000) begin
      bad++;
      $display("FAIL mid_reset got req=%b acks=%b%b", mem_req, inst_ack, data_ack);
    end
    rst = 0; inst_req = 1; inst_addr = 32'h80;
    tick();
    total++;
    if ({mem_req, mem_addr, mem_we, data_ack} !== {1'b1, 32'h80, 2'b00}) begin
      bad++;
      $display("FAIL post_reset_grant got req=%b addr=%h we=%b", mem_req, mem_addr, mem_we);
    end
    mem_ack = 1; mem_rdata = 32'h55;
    tick();
    total++;
    if ({inst_ack, inst_data, data_ack} !== {1'b1, 32'h55, 1'b0}) begin
      bad++;
      $display("FAIL post_reset_ack got ack=%b data=%h dack=%b", inst_ack, inst_data, data_ack);
    end
    mem_ack = 0; inst_req = 0; data_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_round_robin();
    test_timeout();
    test_collision();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
